// File: rtl/aes128_decrypt.sv
// aes128_decrypt: iterative FIPS-197 AES-128 inverse cipher.
// The key schedule is expanded forward into an 11-entry round-key store
// and then consumed in reverse order, one cipher round per clock.
// Optional build macro AES_DEC_KEYCACHE_EN keeps the last expanded key so
// that a job reusing the same key skips key expansion.
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both 1; a producer keeps valid and its payload stable until that edge.
// Input side: in_ready is 1 only in IDLE. Output side: out_valid and
// out_data are held until the edge where out_ready is 1.
module aes128_decrypt (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] inp_data,
    input  logic [127:0] inp_key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data
);

    typedef enum logic [2:0] {IDLE, KEYEXP, ADDKEY, ROUND, DONE} state_e;

    state_e       state_q, state_d;
    logic [127:0] data_q, data_d;
    logic [3:0]   ctr_q, ctr_d;
    logic [127:0] rk_q [0:10];
    logic [127:0] rk_d [0:10];
    logic         in_ready_q, in_ready_d;
    logic         out_valid_q, out_valid_d;
    logic [127:0] out_data_q, out_data_d;
    logic [127:0] key_next;
    logic [127:0] round_out;
`ifdef AES_DEC_KEYCACHE_EN
    logic         cache_valid_q, cache_valid_d;
`endif

    // GF(2^8) doubling modulo x^8+x^4+x^3+x+1
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254 (maps 0 to 0, as the S-box needs)
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = gf_mul(a, a);
        acc = sq;
        for (int i = 0; i < 6; i++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] a, input int n);
        return 8'((a << n) | (a >> (8 - n)));
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] b;
        b = gf_inv(x);
        return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] y);
        return gf_inv(rotl(y, 1) ^ rotl(y, 3) ^ rotl(y, 6) ^ 8'h05);
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] i);
        case (i)
            4'd0:    return 8'h01;
            4'd1:    return 8'h02;
            4'd2:    return 8'h04;
            4'd3:    return 8'h08;
            4'd4:    return 8'h10;
            4'd5:    return 8'h20;
            4'd6:    return 8'h40;
            4'd7:    return 8'h80;
            4'd8:    return 8'h1b;
            4'd9:    return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    // One forward key-schedule step: round key i -> round key i+1
    function automatic logic [127:0] next_key(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] t, w0, w1, w2, w3;
        t  = {sbox(k[23:16]), sbox(k[15:8]), sbox(k[7:0]), sbox(k[31:24])} ^ {rc, 24'h0};
        w0 = k[127:96] ^ t;
        w1 = k[95:64] ^ w0;
        w2 = k[63:32] ^ w1;
        w3 = k[31:0] ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    // InvShiftRows + InvSubBytes + AddRoundKey, then InvMixColumns unless last
    function automatic logic [127:0] inv_round(input logic [127:0] s, input logic [127:0] rk,
                                               input logic last);
        logic [7:0]   b [0:15];
        logic [127:0] r;
        for (int c = 0; c < 4; c++) begin
            for (int rw = 0; rw < 4; rw++) begin
                b[4*c+rw] = inv_sbox(s[127-8*(4*((c-rw+4)%4)+rw) -: 8]) ^ rk[127-8*(4*c+rw) -: 8];
            end
        end
        for (int c = 0; c < 4; c++) begin
            if (last) begin
                r[127-32*c -: 32] = {b[4*c], b[4*c+1], b[4*c+2], b[4*c+3]};
            end else begin
                r[127-32*c -: 32] = {
                    gf_mul(b[4*c], 8'h0e) ^ gf_mul(b[4*c+1], 8'h0b) ^ gf_mul(b[4*c+2], 8'h0d) ^ gf_mul(b[4*c+3], 8'h09),
                    gf_mul(b[4*c], 8'h09) ^ gf_mul(b[4*c+1], 8'h0e) ^ gf_mul(b[4*c+2], 8'h0b) ^ gf_mul(b[4*c+3], 8'h0d),
                    gf_mul(b[4*c], 8'h0d) ^ gf_mul(b[4*c+1], 8'h09) ^ gf_mul(b[4*c+2], 8'h0e) ^ gf_mul(b[4*c+3], 8'h0b),
                    gf_mul(b[4*c], 8'h0b) ^ gf_mul(b[4*c+1], 8'h0d) ^ gf_mul(b[4*c+2], 8'h09) ^ gf_mul(b[4*c+3], 8'h0e)};
            end
        end
        return r;
    endfunction

    // Shared datapaths: a single key-step and a single round, both indexed by the counter
    assign key_next  = next_key(rk_q[ctr_q], rcon(ctr_q));
    assign round_out = inv_round(data_q, rk_q[ctr_q], ctr_q == 4'd0);

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

    // Next-state and datapath control for the five-state job sequencer
    always_comb begin
        state_d     = state_q;
        data_d      = data_q;
        ctr_d       = ctr_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        for (int i = 0; i < 11; i++) rk_d[i] = rk_q[i];
`ifdef AES_DEC_KEYCACHE_EN
        cache_valid_d = cache_valid_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    data_d     = inp_data;
                    rk_d[0]    = inp_key;
                    ctr_d      = 4'd0;
                    in_ready_d = 1'b0;
`ifdef AES_DEC_KEYCACHE_EN
                    if (cache_valid_q && (inp_key == rk_q[0])) begin
                        state_d = ADDKEY;
                    end else begin
                        state_d       = KEYEXP;
                        cache_valid_d = 1'b0;
                    end
`else
                    state_d = KEYEXP;
`endif
                end
            end
            KEYEXP: begin
                for (int i = 1; i < 11; i++) begin
                    if (i == int'(ctr_q) + 1) rk_d[i] = key_next;
                end
                if (ctr_q == 4'd9) begin
                    state_d = ADDKEY;
                    ctr_d   = 4'd0;
`ifdef AES_DEC_KEYCACHE_EN
                    cache_valid_d = 1'b1;
`endif
                end else begin
                    ctr_d = ctr_q + 4'd1;
                end
            end
            ADDKEY: begin
                data_d  = data_q ^ rk_q[10];
                ctr_d   = 4'd9;
                state_d = ROUND;
            end
            ROUND: begin
                data_d = round_out;
                if (ctr_q == 4'd0) begin
                    out_data_d  = round_out;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    ctr_d = ctr_q - 4'd1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State, datapath and registered outputs; reset abandons any job in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            data_q      <= '0;
            ctr_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            for (int i = 0; i < 11; i++) rk_q[i] <= '0;
`ifdef AES_DEC_KEYCACHE_EN
            cache_valid_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            ctr_q       <= ctr_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            for (int i = 0; i < 11; i++) rk_q[i] <= rk_d[i];
`ifdef AES_DEC_KEYCACHE_EN
            cache_valid_q <= cache_valid_d;
`endif
        end
    end

endmodule

// File: tb/tb_aes128_decrypt.sv
// Self-checking bench for aes128_decrypt. Expected plaintexts come from
// known-answer vectors and from an AES-128 encryptor model written over
// byte arrays; latency expectations follow the key-cache build option.
module tb_aes128_decrypt;

    logic         clk;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] inp_data;
    logic [127:0] inp_key;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0]   sbox_t [256];
    logic [127:0] exp_q [$];
    logic [127:0] cache_key;
    bit           cache_ok;

    aes128_decrypt dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .inp_data  (inp_data),
        .inp_key   (inp_key),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box table: brute-force inverse, then the affine map bit by bit
    task automatic build_sbox();
        logic [7:0] inv;
        logic [7:0] s;
        logic [7:0] c;
        c = 8'h63;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (m_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            for (int i = 0; i < 8; i++) begin
                s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
            end
            sbox_t[x] = s;
        end
    endtask

    function automatic logic [127:0] model_encrypt(input logic [127:0] key, input logic [127:0] pt);
        logic [31:0]  w [44];
        logic [31:0]  t;
        logic [7:0]   rc;
        logic [7:0]   s [16];
        logic [7:0]   u [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] r;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]], sbox_t[t[31:24]]} ^ {rc, 24'h0};
                rc = m_mul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int k = 0; k < 16; k++) s[k] = pt[127-8*k -: 8] ^ w[k/4][31-8*(k%4) -: 8];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int k = 0; k < 16; k++) u[k] = sbox_t[s[k]];
            for (int c = 0; c < 4; c++)
                for (int rw = 0; rw < 4; rw++) s[4*c+rw] = u[4*((c+rw)%4)+rw];
            if (rnd < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                    s[4*c]   = m_mul(a0, 8'h02) ^ m_mul(a1, 8'h03) ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ m_mul(a1, 8'h02) ^ m_mul(a2, 8'h03) ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ m_mul(a2, 8'h02) ^ m_mul(a3, 8'h03);
                    s[4*c+3] = m_mul(a0, 8'h03) ^ a1 ^ a2 ^ m_mul(a3, 8'h02);
                end
            end
            for (int k = 0; k < 16; k++) s[k] = s[k] ^ w[4*rnd + k/4][31-8*(k%4) -: 8];
        end
        for (int k = 0; k < 16; k++) r[127-8*k -: 8] = s[k];
        return r;
    endfunction

    function automatic int exp_latency(input logic [127:0] key);
`ifdef AES_DEC_KEYCACHE_EN
        return (cache_ok && key == cache_key) ? 11 : 21;
`else
        return 21;
`endif
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Offers a job and returns #1 after the accept edge with in_valid dropped
    task automatic start_job(input logic [127:0] key, input logic [127:0] ct, input string tag);
        int w;
        w = 0;
        while (!in_ready && w < 100) begin
            @(posedge clk); #1;
            w++;
        end
        check({tag, "_ready_wait"}, 128'(in_ready), 128'(1));
        in_valid = 1'b1;
        inp_data = ct;
        inp_key  = key;
        @(posedge clk); #1;
        in_valid = 1'b0;
        inp_data = rand128();
        inp_key  = rand128();
    endtask

    // Waits for the result, checks latency/data, optionally stalls, then consumes
    task automatic finish_job(input logic [127:0] key, input logic [127:0] exp_pt, input int exp_lat,
                              input int hold, input bit early, input bit pulse, input string tag);
        int lat;
        lat = 0;
        out_ready = early;
        while (!out_valid && lat < 60) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_latency"}, 128'(lat), 128'(exp_lat));
        if (!out_valid) begin
            out_ready = 1'b0;
            return;
        end
        check({tag, "_data"}, out_data, exp_pt);
        for (int h = 0; h < hold; h++) begin
            if (pulse && h == 5) begin
                in_valid = 1'b1;
                inp_data = rand128();
                inp_key  = key;
            end
            if (pulse && h == 6) in_valid = 1'b0;
            @(posedge clk); #1;
            check({tag, "_hold_valid"}, 128'(out_valid), 128'(1));
            check({tag, "_hold_data"}, out_data, exp_pt);
            check({tag, "_hold_in_ready"}, 128'(in_ready), 128'(0));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check({tag, "_consumed_valid"}, 128'(out_valid), 128'(0));
        check({tag, "_consumed_in_ready"}, 128'(in_ready), 128'(1));
        out_ready = 1'b0;
        cache_ok  = 1'b1;
        cache_key = key;
    endtask

    task automatic run_job(input logic [127:0] key, input logic [127:0] ct, input logic [127:0] exp_pt,
                           input int hold, input bit early, input string tag);
        int lat;
        lat = exp_latency(key);
        start_job(key, ct, tag);
        finish_job(key, exp_pt, lat, hold, early, 1'b0, tag);
    endtask

    // ---------------- stimulus ----------------
    localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] P1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] K2  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] C2  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] P2  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] KRT = 128'h0123456789ABCDEF0123456789ABCDEF;
    localparam logic [127:0] PRT = 128'hd7e5dbd3324595f8fdc7d7c571da6c2a;

    initial begin
        logic [127:0] key, pt, ct, prev_key;
        logic [127:0] b_key [3];
        logic [127:0] b_ct  [3];
        int           acc_edge [3];
        int           n_acc, n_done, lat;
        bit           prev_rdy, seen;

        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        inp_data  = '0;
        inp_key   = '0;
        cache_ok  = 1'b0;
        cache_key = '0;
        build_sbox();

        // Reset values before any clock edge
        #3;
        check("reset_out_valid", 128'(out_valid), 128'(0));
        check("reset_out_data", out_data, 128'(0));
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("release_in_ready", 128'(in_ready), 128'(1));

        // Known-answer vectors; first accept on the first edge after release
        run_job(K1, C1, P1, 0, 1'b0, "kat1");
        run_job(K2, C2, P2, 0, 1'b0, "kat2");
        run_job(K2, C2, P2, 0, 1'b0, "kat2_repeat");
        run_job(K1, C1, P1, 0, 1'b0, "kat1_newkey");

        // Consumer stalls 15 cycles in DONE with an in_valid pulse that must be ignored
        lat = exp_latency(K2);
        start_job(K2, C2, "stall");
        finish_job(K2, P2, lat, 15, 1'b0, 1'b1, "stall");
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (out_valid || !in_ready) seen = 1'b1;
        end
        check("stall_pulse_ignored", 128'(seen), 128'(0));

        // Reset in the middle of a job abandons it
        start_job(K1, C1, "abort");
        repeat (7) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("abort_out_valid", 128'(out_valid), 128'(0));
        check("abort_out_data", out_data, 128'(0));
        cache_ok = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("abort_in_ready", 128'(in_ready), 128'(1));
        seen = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        check("abort_no_output", 128'(seen), 128'(0));
        run_job(K1, C1, P1, 0, 1'b0, "after_abort");

        // Round trip through the encryptor model
        ct = model_encrypt(KRT, PRT);
        run_job(KRT, ct, PRT, 0, 1'b0, "roundtrip");

        // Random jobs, some reusing the previous key, random consumer behaviour
        prev_key = KRT;
        for (int j = 0; j < 6; j++) begin
            key = (j % 3 == 1) ? prev_key : rand128();
            pt  = rand128();
            ct  = model_encrypt(key, pt);
            lat = $urandom_range(0, 3);
            run_job(key, ct, pt, lat, (lat == 0) && ($urandom_range(0, 1) == 1), $sformatf("rand%0d", j));
            prev_key = key;
        end

        // Back-to-back: in_valid and out_ready held high, distinct keys
        for (int j = 0; j < 3; j++) begin
            b_key[j] = rand128();
            pt       = rand128();
            b_ct[j]  = model_encrypt(b_key[j], pt);
            exp_q.push_back(pt);
        end
        out_ready = 1'b1;
        in_valid  = 1'b1;
        inp_key   = b_key[0];
        inp_data  = b_ct[0];
        prev_rdy  = in_ready;
        n_acc     = 0;
        n_done    = 0;
        for (int e = 0; e < 200 && n_done < 3; e++) begin
            @(posedge clk); #1;
            if (prev_rdy && in_valid) begin
                acc_edge[n_acc] = e;
                n_acc++;
                if (n_acc < 3) begin
                    inp_key  = b_key[n_acc];
                    inp_data = b_ct[n_acc];
                end else begin
                    in_valid = 1'b0;
                end
            end
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("b2b_extra_output", 128'(1), 128'(0));
                end else begin
                    check($sformatf("b2b_data%0d", n_done), out_data, exp_q.pop_front());
                end
                n_done++;
            end
            prev_rdy = in_ready;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("b2b_outputs", 128'(n_done), 128'(3));
        check("b2b_accepts", 128'(n_acc), 128'(3));
        if (n_acc == 3) begin
            check("b2b_gap01", 128'(acc_edge[1] - acc_edge[0]), 128'(23));
            check("b2b_gap12", 128'(acc_edge[2] - acc_edge[1]), 128'(23));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Global time limit so the run always ends
    initial begin
        #2000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "time limit reached");
    end

endmodule
